seq_pattern_tx: RTL and testbench

Serial pattern transmitter: the driving end of the single-bit serial interface consumed by the team's Mealy sequence detectors. On a `start` pulse it emits a compile-time bit pattern MSB-first, one bit per clock, repeated a programmable number of times. The serial output feeds a detector's `x` input directly, for stimulus generation and for on-chip loopback self-test.

---
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated `count` times.
// Define SEQ_TX_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_pattern_tx #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = 4'b1101,
  parameter int unsigned       GAP_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] count,
  input  logic       abort,
  output logic       x,
  output logic       x_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(WIDTH);

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       rep_q, rep_d;
`ifdef SEQ_TX_GAP_EN
  logic [3:0]       gap_cnt_q, gap_cnt_d;
`endif
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
`ifdef SEQ_TX_GAP_EN
      gap_cnt_q <= '0;
`endif
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
`ifdef SEQ_TX_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // shift_q holds the bit currently on x at its MSB while in SEND.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
`ifdef SEQ_TX_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (count != 8'd0) begin
              rep_d     = count;
              shift_d   = PATTERN;
              bit_cnt_d = CW'(WIDTH - 1);
              state_d   = SEND;
            end else begin
              state_d = DONE;
            end
          end
        end
        SEND: begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == '0) begin
            rep_d = rep_q - 8'd1;
            if (rep_q == 8'd1) begin
              state_d = DONE;
            end else begin
`ifdef SEQ_TX_GAP_EN
              gap_cnt_d = 4'(GAP_LEN - 1);
              state_d   = GAP;
`else
              shift_d   = PATTERN;
              bit_cnt_d = CW'(WIDTH - 1);
`endif
            end
          end else begin
            bit_cnt_d = bit_cnt_q - CW'(1);
          end
        end
`ifdef SEQ_TX_GAP_EN
        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            shift_d   = PATTERN;
            bit_cnt_d = CW'(WIDTH - 1);
            state_d   = SEND;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    x_valid_d = (state_d == SEND);
    x_d       = (state_d == SEND) && shift_d[WIDTH-1];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: model pushes (cycle, bit) items, monitor pops.
module tb_seq_pattern_tx;

  localparam int unsigned      W   = 4;
  localparam logic [W-1:0]     PAT = 4'b1101;
  localparam int unsigned      GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] count;
  logic       abort;
  logic       x, x_valid, busy, done;

  seq_pattern_tx #(.WIDTH(W), .PATTERN(PAT), .GAP_LEN(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .abort(abort),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic xb;
    logic is_done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: pattern MSB-first per repetition, optional idle gap, then done.
  task automatic push_expect(input int n0, input int cnt);
    int off = 0;
    for (int r = 0; r < cnt; r++) begin
      for (int k = W - 1; k >= 0; k--) begin
        q.push_back('{cyc: n0 + off, xb: PAT[k], is_done: 1'b0});
        off++;
      end
`ifdef SEQ_TX_GAP_EN
      if (r < cnt - 1) off += GAP;
`endif
    end
    q.push_back('{cyc: n0 + off, xb: 1'b0, is_done: 1'b1});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (!x_valid && x) begin
        errors++;
        $display("FAIL x_idle_zero cyc=%0d x=%b x_valid=%b required x=0", cyc, x, x_valid);
      end
    end
    if (x_valid === 1'b1 || done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d x=%b x_valid=%b done=%b required none", cyc, x, x_valid, done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.is_done !== done || e.is_done === x_valid ||
            (x_valid && e.xb !== x)) begin
          errors++;
          $display("FAIL stream cyc=%0d x=%b x_valid=%b done=%b required cyc=%0d x=%b done=%b",
                   cyc, x, x_valid, done, e.cyc, e.xb, e.is_done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input int cnt, input bit push);
    start = 1'b1;
    count = 8'(cnt);
    tick();
    start = 1'b0;
    if (push) push_expect(cyc, cnt);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 5000), 32'd1);
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; count = '0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // basic two-repetition stream
    start_tx(2, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_idle();
    tick();

    // count = 0: done only, busy for a single cycle
    start_tx(0, 1'b1);
    chk("cnt0_busy", 32'(busy), 32'd1);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_x_valid", 32'(x_valid), 32'd0);
    tick();
    chk("cnt0_busy_drop", 32'(busy), 32'd0);
    wait_idle();
    tick();

    // start during SEND is ignored
    start_tx(2, 1'b1);
    tick();
    start_tx(5, 1'b0);
    wait_idle();
    tick();

    // abort on the third bit, then immediate restart
    start_tx(3, 1'b1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_x_valid", 32'(x_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_remaining", 32'(q.size()), 32'd10);
    q.delete();
    start_tx(3, 1'b1);
    wait_idle();
    tick();

    // abort in IDLE blocks a coincident start
    abort = 1'b1;
    start_tx(3, 1'b0);
    abort = 1'b0;
    chk("idle_abort_blocks", 32'(busy), 32'd0);
    tick();

    // reset mid-stream, start ignored while held
    start_tx(3, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    q.delete();
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_x_valid", 32'(x_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    start_tx(2, 1'b0);
    chk("start_in_rst", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // randomized repetition counts and spacing
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_tx(int'($urandom_range(0, 7)), 1'b1);
      wait_idle();
      tick();
    end

    // maximum count
    start_tx(255, 1'b1);
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
